// File: rtl/pc_imem.sv
// pc_imem: instruction-fetch front end (PC register + read-only IMEM).
// Ports: clk, reset (sync, active-low), next_pc in; current_pc,
//        instruction and decoded fields (opcode..immediate) out.

module pc_imem_pc #(
   parameter int unsigned          WIDTH    = 32,
   parameter logic [WIDTH-1:0]     RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] current_pc
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;

   // Loaded verbatim; the increment lives outside this block.
   assign pc_d = next_pc;

   always_ff @(posedge clk) begin
      if (!reset) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign current_pc = pc_q;

endmodule

module pc_imem_rom #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 64,
   parameter bit          WORD_ADDR = 1'b1
) (
   input  logic [WIDTH-1:0] addr,
   output logic [WIDTH-1:0] instruction
);

   logic [31:0] idx;
   logic [31:0] word;

   assign idx = WORD_ADDR ? 32'(addr) : 32'(addr >> 2);

   // Out-of-range indices read as nop rather than wrapping.
   always_comb begin
      word = 32'h0000_0000;
      if (idx < DEPTH) begin
         unique case (idx)
            32'd0:   word = 32'h2001_0005;
            32'd1:   word = 32'h2002_000A;
            32'd2:   word = 32'h0022_1820;
            32'd3:   word = 32'h0041_2022;
            32'd4:   word = 32'h0022_2824;
            32'd5:   word = 32'h0022_3025;
            32'd6:   word = 32'h0022_382A;
            32'd7:   word = 32'hAC03_0000;
            32'd8:   word = 32'h8C08_0000;
            32'd9:   word = 32'h1022_0002;
            32'd10:  word = 32'h0800_0000;
            default: word = 32'h0000_0000;
         endcase
      end
   end

   assign instruction = WIDTH'(word);

endmodule

module pc_imem #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      DEPTH     = 64,
   parameter bit               WORD_ADDR = 1'b1,
   parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] next_pc,
   output logic [WIDTH-1:0] current_pc,
   output logic [WIDTH-1:0] instruction,
   output logic [5:0]       opcode,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       shamt,
   output logic [5:0]       funct,
   output logic [15:0]      immediate
);

   pc_imem_pc #(
      .WIDTH    (WIDTH),
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk        (clk),
      .reset      (reset),
      .next_pc    (next_pc),
      .current_pc (current_pc)
   );

   pc_imem_rom #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .WORD_ADDR (WORD_ADDR)
   ) u_rom (
      .addr        (current_pc),
      .instruction (instruction)
   );

   // Plain slices; meaningful or not depending on format.
   assign opcode    = instruction[31:26];
   assign rs        = instruction[25:21];
   assign rt        = instruction[20:16];
   assign rd        = instruction[15:11];
   assign shamt     = instruction[10:6];
   assign funct     = instruction[5:0];
   assign immediate = instruction[15:0];

endmodule

// File: tb/tb_pc_imem.sv
// tb_pc_imem: scoreboard bench for pc_imem, word- and byte-addressed.
// Drives next_pc/reset, queues expected PC/word, compares after each edge.

module tb_pc_imem;

   typedef struct {
      bit          byte_mode;
      logic [31:0] pc;
      logic [31:0] ins;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] np_w = '0;
   logic [31:0] np_b = '0;

   logic [31:0] pc_w, ins_w, pc_b, ins_b;
   logic [5:0]  op_w, fn_w, op_b, fn_b;
   logic [4:0]  rs_w, rt_w, rd_w, sh_w;
   logic [4:0]  rs_b, rt_b, rd_b, sh_b;
   logic [15:0] im_w, im_b;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   pc_imem #(.WORD_ADDR(1'b1)) u_w (
      .clk(clk), .reset(reset), .next_pc(np_w),
      .current_pc(pc_w), .instruction(ins_w),
      .opcode(op_w), .rs(rs_w), .rt(rt_w), .rd(rd_w),
      .shamt(sh_w), .funct(fn_w), .immediate(im_w)
   );

   pc_imem #(.WORD_ADDR(1'b0)) u_b (
      .clk(clk), .reset(reset), .next_pc(np_b),
      .current_pc(pc_b), .instruction(ins_b),
      .opcode(op_b), .rs(rs_b), .rt(rt_b), .rd(rd_b),
      .shamt(sh_b), .funct(fn_b), .immediate(im_b)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rom(input logic [31:0] i);
      case (i)
         32'd0:   return 32'h2001_0005;
         32'd1:   return 32'h2002_000A;
         32'd2:   return 32'h0022_1820;
         32'd3:   return 32'h0041_2022;
         32'd4:   return 32'h0022_2824;
         32'd5:   return 32'h0022_3025;
         32'd6:   return 32'h0022_382A;
         32'd7:   return 32'hAC03_0000;
         32'd8:   return 32'h8C08_0000;
         32'd9:   return 32'h1022_0002;
         32'd10:  return 32'h0800_0000;
         default: return 32'h0000_0000;
      endcase
   endfunction

   task automatic compare_one(input exp_t e);
      logic [31:0] pc, ins, flds;
      logic [15:0] im;
      string       s;
      s = e.byte_mode ? "B" : "W";
      if (e.byte_mode) begin
         pc = pc_b; ins = ins_b; im = im_b;
         flds = {op_b, rs_b, rt_b, rd_b, sh_b, fn_b};
      end else begin
         pc = pc_w; ins = ins_w; im = im_w;
         flds = {op_w, rs_w, rt_w, rd_w, sh_w, fn_w};
      end
      chk({s, "_pc"},  pc,   e.pc);
      chk({s, "_ins"}, ins,  e.ins);
      chk({s, "_fld"}, flds, e.ins);
      chk({s, "_imm"}, 32'(im), 32'(e.ins[15:0]));
   endtask

   task automatic step(input logic rst,
                       input logic [31:0] nw,
                       input logic [31:0] nb);
      exp_t ew, eb;
      reset = rst;
      np_w  = nw;
      np_b  = nb;
      ew.byte_mode = 1'b0;
      ew.pc  = rst ? nw : 32'h0;
      ew.ins = rom(ew.pc);
      eb.byte_mode = 1'b1;
      eb.pc  = rst ? nb : 32'h0;
      eb.ins = (eb.pc[31:2] < 64) ? rom(32'(eb.pc[31:2])) : 32'h0;
      sb.push_back(ew);
      sb.push_back(eb);
      @(posedge clk);
      #1;
      while (sb.size() > 0) compare_one(sb.pop_front());
   endtask

   task automatic wstep(input logic rst, input logic [31:0] nw);
      step(rst, nw, nw << 2);
   endtask

   initial begin
      // Reset held for two edges with a non-zero next_pc.
      wstep(1'b0, 32'h40);
      wstep(1'b0, 32'h40);
      chk("rst_pc",  pc_w, 32'h0);
      chk("rst_ins", ins_w, 32'h2001_0005);
      chk("rst_op",  32'(op_w), 32'h08);
      chk("rst_rt",  32'(rt_w), 32'd1);
      chk("rst_imm", 32'(im_w), 32'h5);

      // Sequential fetch.
      for (int i = 0; i < 12; i++) begin
         wstep(1'b1, pc_w + 32'd1);
         if (pc_w == 32'd2) begin
            chk("p2_rs", 32'(rs_w), 32'd1);
            chk("p2_rt", 32'(rt_w), 32'd2);
            chk("p2_rd", 32'(rd_w), 32'd3);
            chk("p2_sh", 32'(sh_w), 32'd0);
            chk("p2_fn", 32'(fn_w), 32'h20);
         end
         if (pc_w == 32'd7)  chk("p7",  ins_w, 32'hAC03_0000);
         if (pc_w == 32'd10) chk("p10", ins_w, 32'h0800_0000);
         if (pc_w == 32'd11) chk("p11", ins_w, 32'h0);
      end
      chk("seq_end", pc_w, 32'd12);

      // Out of range.
      wstep(1'b1, 32'd64);
      chk("oor64", ins_w, 32'h0);
      chk("oor64_op", 32'(op_w), 32'h0);
      wstep(1'b1, 32'hFFFF_FFFF);
      chk("oorff", ins_w, 32'h0);
      chk("oorff_im", 32'(im_w), 32'h0);
      wstep(1'b1, 32'd63);
      chk("p63", ins_w, 32'h0);

      // Mid-run reset.
      wstep(1'b1, 32'd5);
      wstep(1'b0, 32'd6);
      chk("mrst_pc",  pc_w, 32'h0);
      chk("mrst_ins", ins_w, 32'h2001_0005);
      wstep(1'b1, 32'd1);
      chk("mrst_res", pc_w, 32'd1);

      // Arbitrary jump.
      wstep(1'b1, 32'd3);
      wstep(1'b1, 32'd9);
      chk("j_pc",  pc_w, 32'd9);
      chk("j_op",  32'(op_w), 32'h04);
      chk("j_imm", 32'(im_w), 32'h2);

      // Byte addressing: 0,4,...,28 on the byte instance.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 32'(i), 32'(4 * i));
         if (pc_b == 32'd8) chk("b8", ins_b, 32'h0022_1820);
      end
      chk("b_end", pc_b, 32'd28);
      step(1'b1, 32'd0, 32'd256);
      chk("b_oor", ins_b, 32'h0);
      step(1'b1, 32'd0, 32'd11);
      chk("b_sub", ins_b, 32'h0022_1820);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=%0d exp=0", n_tests);
      $fatal(1, "timeout");
   end

endmodule
